sign_extend_reg: RTL and testbench

- Registered immediate-extension unit for the simple MIPS32 datapath.
- Widens the 16-bit instruction immediate to a 32-bit operand for the ALU and address path.
- Supports four extension modes: sign, zero, upper-immediate (LUI) and signed byte.
- Output is registered with a valid flag, one cycle after the request.

---
 rtl/ext_pkg.sv | 9 +
 rtl/sign_extend_comb.sv | 20 ++
 rtl/sign_extend_reg.sv | 38 +++
 tb/tb_sign_extend_reg.sv | 134 +++++++++++++
 4 files changed

// File: rtl/ext_pkg.sv
// ext_pkg: mode encodings and widths shared by the immediate-extension unit
package ext_pkg;
   localparam int IMM_W  = 16;
   localparam int WORD_W = 32;
   localparam logic [1:0] EXT_SIGN  = 2'b00;
   localparam logic [1:0] EXT_ZERO  = 2'b01;
   localparam logic [1:0] EXT_UPPER = 2'b10;
   localparam logic [1:0] EXT_BYTE  = 2'b11;
endpackage

// File: rtl/sign_extend_comb.sv
// sign_extend_comb: combinational mode mux widening an immediate to a word
//   mode   - extension mode (EXT_SIGN/EXT_ZERO/EXT_UPPER/EXT_BYTE)
//   data   - immediate field, IN_W bits
//   result - extended word, OUT_W bits (OUT_W must be 2*IN_W for upper mode)
module sign_extend_comb
   import ext_pkg::*;
#(
   parameter int IN_W  = IMM_W,
   parameter int OUT_W = WORD_W
) (
   input  logic [1:0]       mode,
   input  logic [IN_W-1:0]  data,
   output logic [OUT_W-1:0] result
);
   always_comb
      result = mode == EXT_SIGN  ? {{(OUT_W-IN_W){data[IN_W-1]}}, data} :
               mode == EXT_ZERO  ? {{(OUT_W-IN_W){1'b0}}, data} :
               mode == EXT_UPPER ? {data, {(OUT_W-IN_W){1'b0}}} :
                                   {{(OUT_W-8){data[7]}}, data[7:0]};
endmodule

// File: rtl/sign_extend_reg.sv
// sign_extend_reg: registered immediate extension with a one-cycle valid strobe
//   i_clk   - rising-edge clock
//   i_rst_n - asynchronous active-low reset, clears o_data and o_valid
//   i_valid - request strobe; i_mode and i_data sampled when high
//   i_mode  - extension mode
//   i_data  - immediate field
//   o_valid - high for one cycle after each accepted request
//   o_data  - extended result, held between requests
module sign_extend_reg
   import ext_pkg::*;
#(
   parameter int IN_W  = IMM_W,
   parameter int OUT_W = WORD_W
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_valid,
   input  logic [1:0]       i_mode,
   input  logic [IN_W-1:0]  i_data,
   output logic             o_valid,
   output logic [OUT_W-1:0] o_data
);
   logic [OUT_W-1:0] ext;
   sign_extend_comb #(.IN_W(IN_W), .OUT_W(OUT_W)) u_comb (
      .mode   (i_mode),
      .data   (i_data),
      .result (ext)
   );
   // o_data only loads on a request, so X on idle inputs never reaches it
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         o_valid <= 1'b0;
         o_data  <= '0;
      end else begin
         o_valid <= i_valid;
         if (i_valid) o_data <= ext;
      end
endmodule

// File: tb/tb_sign_extend_reg.sv
// tb_sign_extend_reg: scoreboard bench for sign_extend_reg
module tb_sign_extend_reg;
   import ext_pkg::*;
   typedef struct {
      logic [31:0] d;
      int          c;
   } exp_t;
   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        i_valid = 1'b0;
   logic [1:0]  i_mode = 2'b00;
   logic [15:0] i_data = 16'h0;
   logic        o_valid;
   logic [31:0] o_data;
   int          cyc = 0;
   int          checks = 0;
   int          failures = 0;
   exp_t        q[$];
   sign_extend_reg dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_valid (i_valid),
      .i_mode  (i_mode),
      .i_data  (i_data),
      .o_valid (o_valid),
      .o_data  (o_data)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk)
      if (rst_n) begin
         if (o_valid) begin
            checks++;
            if (q.size() == 0) begin
               failures++;
               $display("FAIL spurious_valid cyc=%0d got o_data=%h, required no valid", cyc, o_data);
            end else begin
               exp_t e;
               e = q.pop_front();
               if (o_data !== e.d || cyc != e.c) begin
                  failures++;
                  $display("FAIL result got %h at cyc %0d, required %h at cyc %0d", o_data, cyc, e.d, e.c);
               end
            end
         end else if (q.size() != 0 && q[0].c <= cyc) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            failures++;
            $display("FAIL missing_valid cyc=%0d got o_valid=0, required valid with %h", cyc, e.d);
         end
      end
   task automatic check(input string name, input logic [32:0] got, input logic [32:0] req);
      checks++;
      if (got !== req) begin
         failures++;
         $display("FAIL %s got %h, required %h", name, got, req);
      end
   endtask
   task automatic send(input logic [1:0] m, input logic [15:0] d, input logic [31:0] e);
      @(posedge clk);
      #1;
      i_valid = 1'b1;
      i_mode  = m;
      i_data  = d;
      q.push_back('{d: e, c: cyc + 1});
   endtask
   task automatic idle();
      @(posedge clk);
      #1;
      i_valid = 1'b0;
      i_data  = 16'($urandom);
      i_mode  = 2'($urandom);
   endtask
   initial begin
      #2 rst_n = 1'b0;
      #1 check("reset_async", {o_valid, o_data}, 33'h0);
      i_valid = 1'b1;
      i_data  = 16'h1234;
      repeat (2) begin
         @(posedge clk);
         #1 check("reset_held", {o_valid, o_data}, 33'h0);
      end
      @(negedge clk);
      i_valid = 1'b0;
      rst_n   = 1'b1;
      repeat (2) begin
         send(EXT_SIGN, 16'h800F, 32'hFFFF800F);
         send(EXT_SIGN, 16'h000F, 32'h0000000F);
      end
      send(EXT_ZERO,  16'h800F, 32'h0000800F);
      send(EXT_ZERO,  16'hFFFF, 32'h0000FFFF);
      send(EXT_UPPER, 16'h800F, 32'h800F0000);
      send(EXT_UPPER, 16'h0001, 32'h00010000);
      send(EXT_BYTE,  16'hAB80, 32'hFFFFFF80);
      send(EXT_BYTE,  16'hAB7F, 32'h0000007F);
      send(EXT_SIGN,  16'h7FFF, 32'h00007FFF);
      send(EXT_BYTE,  16'h007F, 32'h0000007F);
      send(EXT_BYTE,  16'h0080, 32'hFFFFFF80);
      for (int m = 0; m < 4; m++) send(2'(m), 16'h0000, 32'h0);
      send(EXT_SIGN,  16'hFFFF, 32'hFFFFFFFF);
      send(EXT_ZERO,  16'hFFFF, 32'h0000FFFF);
      send(EXT_UPPER, 16'hFFFF, 32'hFFFF0000);
      send(EXT_BYTE,  16'hFFFF, 32'hFFFFFFFF);
      idle();
      send(EXT_SIGN, 16'h8000, 32'hFFFF8000);
      idle();
      for (int i = 0; i < 3; i++) begin
         idle();
         check("hold_idle", {o_valid, o_data}, {1'b0, 32'hFFFF8000});
      end
      i_data = 16'hxxxx;
      i_mode = 2'bxx;
      @(posedge clk);
      #1 check("hold_x_inputs", {o_valid, o_data}, {1'b0, 32'hFFFF8000});
      send(EXT_ZERO, 16'h1234, 32'h00001234);
      @(posedge clk);
      #1 check("valid_before_reset", {o_valid, o_data}, {1'b1, 32'h00001234});
      i_valid = 1'b0;
      q.delete();
      #2 rst_n = 1'b0;
      #1 check("reset_midstream", {o_valid, o_data}, 33'h0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) begin
         @(posedge clk);
         #1 check("after_release", {o_valid, o_data}, 33'h0);
      end
      repeat (2) @(posedge clk);
      #1 check("queue_drained", 33'(q.size()), 33'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
